// File: rtl/grid_renderer_if.sv
// Entity-store lookup channel: the renderer asks for one cell colour, the store answers with a
// single-cycle rsp_valid pulse carrying that colour.
interface grid_renderer_if #(
    parameter int COLOR_W = 16
);
    logic               req_valid;
    logic [5:0]         req_x;
    logic [5:0]         req_y;
    logic               rsp_valid;
    logic [COLOR_W-1:0] rsp_data;

    modport master (output req_valid, req_x, req_y, input rsp_valid, rsp_data);
    modport slave  (input req_valid, req_x, req_y, output rsp_valid, rsp_data);
endinterface

// File: rtl/grid_renderer.sv
// Tile-grid pixel renderer with next-cell colour prefetch, snake direction register and game-tick divider.
// Optional build macro GRID_LINES_EN draws a 1-px grid in the last row/column of every cell.
module grid_renderer #(
    parameter int                 X_W         = 9,
    parameter int                 Y_W         = 9,
    parameter int                 CELL_SHIFT  = 3,
    parameter int                 GRID_W      = 40,
    parameter int                 GRID_H      = 30,
    parameter int                 COLOR_W     = 16,
    parameter int                 TICK_FRAMES = 16,
    parameter logic [COLOR_W-1:0] MISS_COLOR  = 16'hF800
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic               de,
    input  logic               vsync,
    input  logic [3:0]         mov,
    grid_renderer_if.master    ent,
    output logic [COLOR_W-1:0] pixel_data,
    output logic [1:0]         mov_dir,
    output logic               tick,
    output logic               underrun
);

    localparam int                 CX_W       = X_W - CELL_SHIFT;
    localparam int                 CY_W       = Y_W - CELL_SHIFT + 1;
    localparam int                 FC_W       = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [CX_W-1:0]    LAST_CX    = CX_W'(GRID_W - 1);
    localparam logic [CY_W-1:0]    ROWS       = CY_W'(GRID_H);
    localparam logic [Y_W:0]       ONE_Y      = (Y_W+1)'(1);
    localparam logic [FC_W-1:0]    LAST_FRAME = FC_W'(TICK_FRAMES - 1);
    localparam logic [COLOR_W-1:0] LINE_COLOR = COLOR_W'(16'h2104);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, READY} state_t;

    state_t             state_reg, state_next;
    logic [5:0]         req_x_reg, req_y_reg;
    logic [COLOR_W-1:0] staging_reg;
    logic [COLOR_W-1:0] cell_color_reg, cell_color_next;
    logic [COLOR_W-1:0] pixel_reg, pixel_next;
    logic               underrun_reg;
    logic               miss;

    logic [1:0]         pending_reg, pending_next;
    logic [1:0]         mov_dir_reg;
    logic [1:0]         key_dir;
    logic               vsync_reg;
    logic [FC_W-1:0]    frame_cnt_reg;
    logic               tick_reg, tick_next;
    logic               vsync_rise;

    logic               cell_start;
    logic               on_grid_line;
    logic [CX_W-1:0]    cx;
    logic [CY_W-1:0]    cy_raw, cy, ny_raw, ny;
    logic [5:0]         target_x, target_y;

    assign cell_start = de & (x[CELL_SHIFT-1:0] == '0);
    assign cx         = x[X_W-1:CELL_SHIFT];
    assign cy_raw     = {1'b0, y[Y_W-1:CELL_SHIFT]};
    assign cy         = cy_raw % ROWS;
    assign ny_raw     = CY_W'(({1'b0, y} + ONE_Y) >> CELL_SHIFT);
    assign ny         = ny_raw % ROWS;

`ifdef GRID_LINES_EN
    assign on_grid_line = (&x[CELL_SHIFT-1:0]) | (&y[CELL_SHIFT-1:0]);
`else
    assign on_grid_line = 1'b0;
`endif

    // The last column of a line prefetches column 0 of the following line (wrapping to row 0).
    always_comb begin
        target_x = '0;
        target_y = 6'(ny);
        if (cx < LAST_CX) begin
            target_x = 6'(cx + CX_W'(1));
            target_y = 6'(cy);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            REQ:         state_next = WAIT;
            WAIT:        if (ent.rsp_valid) state_next = READY;
            IDLE, READY: state_next = state_reg;
            default:     state_next = IDLE;
        endcase
        if (cell_start) state_next = REQ;
    end

    // A cell start while the fetch is still outstanding shows MISS_COLOR; straight after reset shows 0.
    always_comb begin
        cell_color_next = cell_color_reg;
        miss            = 1'b0;
        if (cell_start) begin
            case (state_reg)
                READY:     cell_color_next = staging_reg;
                REQ, WAIT: begin
                    cell_color_next = MISS_COLOR;
                    miss            = 1'b1;
                end
                default:   cell_color_next = '0;
            endcase
        end
        if (!de)               pixel_next = '0;
        else if (on_grid_line) pixel_next = LINE_COLOR;
        else                   pixel_next = cell_color_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            req_x_reg      <= '0;
            req_y_reg      <= '0;
            staging_reg    <= '0;
            cell_color_reg <= '0;
            pixel_reg      <= '0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cell_color_reg <= cell_color_next;
            pixel_reg      <= pixel_next;
            if (cell_start) begin
                req_x_reg <= target_x;
                req_y_reg <= target_y;
            end
            if (state_reg == WAIT && ent.rsp_valid) staging_reg <= ent.rsp_data;
            if (miss) underrun_reg <= 1'b1;
        end
    end

    // Lowest-index key wins first; only then is it rejected if it reverses the applied direction.
    always_comb begin
        key_dir      = '0;
        pending_next = pending_reg;
        for (int i = 3; i >= 0; i--) begin
            if (mov[i]) key_dir = 2'(i);
        end
        if ((|mov) && (key_dir != (mov_dir_reg ^ 2'd2))) pending_next = key_dir;
    end

    assign vsync_rise = vsync & ~vsync_reg;
    assign tick_next  = vsync_rise && (frame_cnt_reg == LAST_FRAME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_reg     <= 1'b0;
            frame_cnt_reg <= '0;
            tick_reg      <= 1'b0;
            pending_reg   <= '0;
            mov_dir_reg   <= '0;
        end else begin
            vsync_reg   <= vsync;
            tick_reg    <= tick_next;
            pending_reg <= pending_next;
            if (vsync_rise) frame_cnt_reg <= tick_next ? '0 : frame_cnt_reg + FC_W'(1);
            if (tick_next)  mov_dir_reg   <= pending_reg;
        end
    end

    assign ent.req_valid = (state_reg == REQ);
    assign ent.req_x     = req_x_reg;
    assign ent.req_y     = req_y_reg;
    assign pixel_data    = pixel_reg;
    assign mov_dir       = mov_dir_reg;
    assign tick          = tick_reg;
    assign underrun      = underrun_reg;

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: steady line, late response, frame wrap, direction guard, tick divider, async reset.
module tb_grid_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  x, y;
    logic        de, vsync;
    logic [3:0]  mov;
    logic [15:0] pixel_data;
    logic [1:0]  mov_dir;
    logic        tick, underrun;

    grid_renderer_if #(.COLOR_W(16)) bus ();

    grid_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .de         (de),
        .vsync      (vsync),
        .mov        (mov),
        .ent        (bus),
        .pixel_data (pixel_data),
        .mov_dir    (mov_dir),
        .tick       (tick),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          rsp_lat = 2;
    logic [15:0] fixed_color = 16'h1234;
    int          tick_cnt = 0;
    int          wide_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int px, input int py, input logic pde);
        x  = 9'(px);
        y  = 9'(py);
        de = pde;
        step();
    endtask

    task automatic idle(input int n);
        de = 1'b0;
        x  = '0;
        repeat (n) step();
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (2) step();
        vsync = 1'b0;
        repeat (2) step();
    endtask

    // Entity store: row 5 answers column+1, every other row answers fixed_color, rsp_lat cycles after req_valid.
    initial begin
        int          cnt;
        logic [15:0] hold;
        cnt           = 0;
        hold          = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = hold;
                end
            end
            if (bus.req_valid === 1'b1) begin
                cnt  = rsp_lat;
                hold = (bus.req_y == 6'd5) ? 16'(bus.req_x) + 16'd1 : fixed_color;
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) begin
                tick_cnt++;
                if (prev) wide_cnt++;
            end
            prev = tick;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, w0, nreq;
        rst_n = 1'b0;
        x = '0; y = '0; de = 1'b0; vsync = 1'b0; mov = '0;
        repeat (3) step();
        check("rst_pixel", pixel_data, 0);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_req_x", bus.req_x, 0);
        check("rst_req_y", bus.req_y, 0);
        check("rst_mov_dir", mov_dir, 0);
        check("rst_tick", tick, 0);
        check("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        idle(2);

        // Steady line: last cell of y=39 prefetches (0,5), then row 5 steps through 1..40.
        for (int px = 312; px < 320; px++) drive(px, 39, 1'b1);
        idle(16);
        for (int px = 0; px < 320; px++) begin
            drive(px, 40, 1'b1);
            if (px % 8 == 0) check($sformatf("row5_c%0d", px / 8), pixel_data, px / 8 + 1);
        end
        check("steady_underrun", underrun, 0);

        // Late response: latency 7 leaves the FSM in WAIT at the next cell start.
        idle(16);
        rsp_lat = 7;
        for (int px = 0; px < 16; px++) begin
            drive(px, 41, 1'b1);
            if (px == 0) check("late_prev_cell", pixel_data, 16'h0001);
            if (px == 8) begin
                check("late_miss_color", pixel_data, 16'hF800);
                check("late_underrun", underrun, 1);
            end
            if (px == 9) rsp_lat = 2;
        end
        idle(16);
        check("underrun_sticky", underrun, 1);

        // Reversal guard: down then left inside one tick must apply down.
        check("dir_init", mov_dir, 0);
        mov = 4'b0010; step();
        mov = 4'b0100; step();
        mov = 4'b0000; step();
        check("dir_before_tick", mov_dir, 0);
        t0 = tick_cnt;
        repeat (16) vs_pulse();
        check("tick_after_16", tick_cnt - t0, 1);
        check("dir_after_tick1", mov_dir, 1);
        mov = 4'b0100; step();
        mov = 4'b0000; step();
        check("dir_held_until_tick", mov_dir, 1);
        repeat (16) vs_pulse();
        check("dir_after_tick2", mov_dir, 2);

        // Tick divider: 48 further vsync edges give exactly 3 single-cycle pulses.
        t0 = tick_cnt;
        w0 = wide_cnt;
        repeat (48) vs_pulse();
        check("tick_count_48", tick_cnt - t0, 3);
        check("tick_width", wide_cnt - w0, 0);

        // Frame wrap: the last cell of the last line prefetches (0,0).
        rsp_lat     = 3;
        fixed_color = 16'h07E0;
        for (int px = 312; px < 320; px++) begin
            drive(px, 239, 1'b1);
            if (px == 312) begin
                check("wrap_req_valid", bus.req_valid, 1);
                check("wrap_req_x", bus.req_x, 0);
                check("wrap_req_y", bus.req_y, 0);
            end
        end
        idle(20);
        drive(0, 0, 1'b1);
        check("wrap_pixel00", pixel_data, 16'h07E0);

        // Async reset in WAIT, between clock edges.
        drive(1, 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pixel", pixel_data, 0);
        check("arst_req_valid", bus.req_valid, 0);
        check("arst_underrun", underrun, 0);
        check("arst_mov_dir", mov_dir, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        idle(2);
        nreq = 0;
        for (int px = 8; px < 16; px++) begin
            drive(px, 0, 1'b1);
            if (bus.req_valid === 1'b1) nreq++;
            if (px == 8) begin
                check("post_rst_pixel", pixel_data, 0);
                check("post_rst_req_x", bus.req_x, 2);
                check("post_rst_req_y", bus.req_y, 0);
            end
        end
        check("post_rst_req_count", nreq, 1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
